tqvp_neuro_spike_encoder: RTL

TQVP_NEURO_SPIKE_ENCODER -- requirements
Module: tqvp_neuro_spike_encoder

---
 rtl/tqvp_neuro_spike_encoder_pkg.sv | 32 +++
 rtl/tqvp_neuro_spike_encoder_if.sv | 17 +
 rtl/tqvp_spike_cmd_fifo.sv | 57 +++++
 rtl/tqvp_neuro_spike_encoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tqvp_neuro_spike_encoder_pkg.sv
// Shared definitions for the spike encoder: register map, FSM states,
// spike directions, command FIFO geometry and the timing-clamp helpers.
package tqvp_neuro_spike_enc_pkg;

   localparam logic [5:0] ADDR_CMD    = 6'h00;
   localparam logic [5:0] ADDR_CFG    = 6'h04;
   localparam logic [5:0] ADDR_STATUS = 6'h08;
   localparam logic [5:0] ADDR_SPIKES = 6'h0C;
   localparam logic [5:0] ADDR_CTRL   = 6'h10;

   localparam int FIFO_DEPTH = 4;
   localparam int CMD_W      = 18;   // {dir[1:0], count[15:0]}

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HIGH, ST_LOW} state_e;
   typedef enum logic [1:0] {DIR_E = 2'd0, DIR_N = 2'd1, DIR_W = 2'd2, DIR_S = 2'd3} dir_e;

   // A period below 2 cannot hold both a high and a low phase.
   function automatic logic [7:0] period_eff(input logic [7:0] p);
      return (p < 8'd2) ? 8'd2 : p;
   endfunction

   // Keep at least one low cycle so consecutive pulses stay distinguishable.
   function automatic logic [7:0] width_eff(input logic [7:0] w, input logic [7:0] pe);
      if (w == 8'd0)
         return 8'd1;
      else if (w > pe - 8'd1)
         return pe - 8'd1;
      else
         return w;
   endfunction

endpackage

// File: rtl/tqvp_neuro_spike_encoder_if.sv
// Register bus between host and spike encoder.
//   address/data_in/data_write_n/data_read_n : host -> encoder
//   data_out/data_ready/user_interrupt        : encoder -> host
interface tqvp_neuro_spike_encoder_if;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   modport master (output address, data_in, data_write_n, data_read_n,
                   input  data_out, data_ready, user_interrupt);
   modport slave  (input  address, data_in, data_write_n, data_read_n,
                   output data_out, data_ready, user_interrupt);
endinterface

// File: rtl/tqvp_spike_cmd_fifo.sv
// Command FIFO, 18 bits wide, 4 entries, head visible combinationally.
//   i_push/i_data : enqueue; dropped when full unless i_pop in same cycle
//   i_pop         : dequeue head (ignored when empty)
//   i_flush       : empty the FIFO; overrides push and pop
//   o_head, o_level, o_full, o_empty : current state
module tqvp_spike_cmd_fifo
   import tqvp_neuro_spike_enc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [CMD_W-1:0] i_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [CMD_W-1:0] o_head,
   output logic [2:0]       o_level,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [2:0]       r_level;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_level   = r_level;
   assign o_full    = (r_level == 3'(FIFO_DEPTH));
   assign o_empty   = (r_level == 3'd0);
   assign o_head    = r_mem[r_rptr];
   assign w_do_pop  = i_pop && !o_empty && !i_flush;
   // A pop in the same cycle frees the slot the push needs.
   assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         r_level <= r_level + {2'd0, w_do_push} - {2'd0, w_do_pop};
      end
   end
endmodule

// File: rtl/tqvp_neuro_spike_encoder.sv
// Spike encoder: queued {dir,count} commands become trains of pulses on one
// of four spike lines, with programmable period/width and a pause input.
//   clk, rst_n : clock, asynchronous active-low reset
//   ui_in[0]   : pause (freezes the low-phase timer)
//   uo_out     : [3:0] spike lines E,N,W,S, [4] busy, [7:5] zero
//   bus        : register access (CMD, CFG, STATUS, SPIKES, CTRL), interrupt
module tqvp_neuro_spike_encoder
   import tqvp_neuro_spike_enc_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  ui_in,
   output logic [7:0]                  uo_out,
   tqvp_neuro_spike_encoder_if.slave   bus
);
   logic        r_enable, r_irq_en, r_overflow, r_done;
   logic [7:0]  r_period, r_width_cfg;
   logic [31:0] r_spikes;

   state_e      r_state, w_state_next;
   dir_e        r_dir, w_dir_next;
   logic [15:0] r_remaining, w_remaining_next;
   logic [7:0]  r_timer, w_timer_next;
   logic [7:0]  r_hi_len, w_hi_next;
   logic [7:0]  r_lo_len, w_lo_next;
   logic        w_complete, w_spike;

   logic        w_wr, w_cmd_wr, w_cfg_wr, w_ctrl_wr, w_flush, w_pop, w_busy;
   logic [CMD_W-1:0] w_head;
   logic [2:0]  w_level;
   logic        w_full, w_empty;
   logic [7:0]  w_pe, w_we;
   logic [3:0]  w_lines;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_wr      = (bus.data_write_n != 2'b11);
   assign w_cmd_wr  = w_wr && (bus.address == ADDR_CMD);
   assign w_cfg_wr  = w_wr && (bus.address == ADDR_CFG);
   assign w_ctrl_wr = w_wr && (bus.address == ADDR_CTRL);
   assign w_flush   = w_ctrl_wr && bus.data_in[2];
   assign w_pop     = (r_state == ST_IDLE) && r_enable && !w_empty && !w_flush;
   assign w_busy    = (r_state != ST_IDLE);
   assign w_pe      = period_eff(r_period);
   assign w_we      = width_eff(r_width_cfg, w_pe);
   assign w_unused  = &{1'b0, bus.data_read_n, ui_in[7:1], bus.data_in[31:25]};

   tqvp_spike_cmd_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_cmd_wr),
      .i_data  (bus.data_in[CMD_W-1:0]),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_head  (w_head),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // FSM state register (with its datapath)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_dir       <= DIR_E;
         r_remaining <= '0;
         r_timer     <= '0;
         r_hi_len    <= '0;
         r_lo_len    <= '0;
      end else begin
         r_state     <= w_state_next;
         r_dir       <= w_dir_next;
         r_remaining <= w_remaining_next;
         r_timer     <= w_timer_next;
         r_hi_len    <= w_hi_next;
         r_lo_len    <= w_lo_next;
      end
   end

   // Next-state logic. Timers reload with a phase length and expire when
   // they reach 1, so a phase of N cycles spans exactly N clock edges.
   always_comb begin
      w_state_next     = r_state;
      w_dir_next       = r_dir;
      w_remaining_next = r_remaining;
      w_timer_next     = r_timer;
      w_hi_next        = r_hi_len;
      w_lo_next        = r_lo_len;
      w_complete       = 1'b0;
      w_spike          = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_pop) begin
               w_state_next     = ST_LOAD;
               w_dir_next       = dir_e'(w_head[17:16]);
               w_remaining_next = w_head[15:0];
            end
         end
         ST_LOAD: begin
            w_hi_next = w_we;
            w_lo_next = w_pe - w_we;
            if (r_remaining == 16'd0) begin
               w_state_next = ST_IDLE;
               w_complete   = 1'b1;
            end else begin
               w_state_next = ST_HIGH;
               w_timer_next = w_we;
            end
         end
         ST_HIGH: begin
            if (r_timer <= 8'd1) begin
               w_state_next = ST_LOW;
               w_timer_next = r_lo_len;
               w_spike      = 1'b1;
            end else begin
               w_timer_next = r_timer - 8'd1;
            end
         end
         ST_LOW: begin
            if (!ui_in[0]) begin
               if (r_timer <= 8'd1) begin
                  w_remaining_next = r_remaining - 16'd1;
                  if (r_remaining <= 16'd1) begin
                     w_state_next = ST_IDLE;
                     w_complete   = 1'b1;
                  end else begin
                     w_state_next = ST_HIGH;
                     w_timer_next = r_hi_len;
                  end
               end else begin
                  w_timer_next = r_timer - 8'd1;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      // Flush abandons the command without reporting completion.
      if (w_flush) begin
         w_state_next     = ST_IDLE;
         w_remaining_next = '0;
         w_timer_next     = '0;
         w_complete       = 1'b0;
      end
   end

   // Configuration, counters and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enable    <= 1'b0;
         r_period    <= '0;
         r_width_cfg <= '0;
         r_irq_en    <= 1'b0;
         r_spikes    <= '0;
         r_overflow  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (w_cfg_wr) begin
            r_enable    <= bus.data_in[0];
            r_period    <= bus.data_in[15:8];
            r_width_cfg <= bus.data_in[23:16];
            r_irq_en    <= bus.data_in[24];
         end
         if (w_spike)
            r_spikes <= r_spikes + 32'd1;
         if (w_cmd_wr && w_full && !w_pop)
            r_overflow <= 1'b1;
         else if (w_ctrl_wr && bus.data_in[1])
            r_overflow <= 1'b0;
         // Completion outranks a same-cycle clear.
         if (w_complete && w_empty)
            r_done <= 1'b1;
         else if (w_ctrl_wr && bus.data_in[0])
            r_done <= 1'b0;
      end
   end

   assign w_lines = (r_state == ST_HIGH) ? (4'b0001 << r_dir) : 4'b0000;
   assign uo_out  = {3'b000, w_busy, w_lines};

   always_comb begin
      w_rdata = '0;
      case (bus.address)
         ADDR_CMD:    w_rdata = w_empty ? 32'd0 : {14'd0, w_head};
         ADDR_CFG:    w_rdata = {7'd0, r_irq_en, r_width_cfg, r_period, 7'd0, r_enable};
         ADDR_STATUS: w_rdata = {r_remaining, 8'd0, r_done, r_overflow, w_busy,
                                 w_empty, w_full, w_level};
         ADDR_SPIKES: w_rdata = r_spikes;
         default:     w_rdata = '0;
      endcase
   end

   assign bus.data_out       = w_rdata;
   assign bus.data_ready     = 1'b1;
   assign bus.user_interrupt = r_done && r_irq_en;
endmodule
